cocktail_order_ctrl: RTL
========================

# cocktail_order_ctrl

Order controller feeding the four-digit seven-segment display stage of the cocktail machine. It turns single-cycle button pulses into the `state`, `drink` and `size` values that the display stage shows. It also runs the pour sequence, driving the pump and the per-drink valve for a time proportional to `size`. It sits between the button debouncers and the display and pump drivers.

## Interface
- `TICKS_PER_UNIT`, default 50_000_000: pump cycles per size unit (1 s at 50 MHz).
- `DONE_TICKS`, default 100_000_000: cycles the DONE state is held before returning to ORDER.
- `IDLE_TICKS`, default 500_000_000: CUSTOMIZE inactivity limit; used only with `ORDER_CTRL_TIMEOUT_EN`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_up`  in  1  one-cycle pulse, debounced upstream: increment the field being edited.
- `btn_down`  in  1  one-cycle pulse: decrement the field being edited.
- `btn_confirm`  in  1  one-cycle pulse: advance to the next state.
- `btn_cancel`  in  1  one-cycle pulse: abort and return to ORDER.
- `state`  out  2  00 ORDER, 01 CUSTOMIZE, 10 START (pouring), 11 DONE.
- `drink`  out  3  selected drink, 0..6.
- `size`  out  4  selected size, 1..9.
- `pump_on`  out  1  pump enable; high only in START.
- `valve`  out  7  one-hot drink valve; `valve[drink]`=1 only in START, else 0.

## Operation
- Reset values: `state`=ORDER, `drink`=0, `size`=1, `pump_on`=0, `valve`=0, all counters 0.
- ORDER:
  - up/down change `drink` modulo 7: 6+1→0, 0−1→6.
  - confirm → CUSTOMIZE.
- CUSTOMIZE:
  - up/down change `size`, saturating at 9 and at 1.
  - confirm → START; loads the pour counter with `size*TICKS_PER_UNIT`.
  - cancel → ORDER; `size` is reset to 1 and `drink` is kept.
- START:
  - `pump_on`=1 and `valve[drink]`=1.
  - up/down/confirm are ignored.
  - The counter decrements each cycle. When it reaches 0 the state becomes DONE.
  - cancel → ORDER immediately; pump and valve drop the same edge.
- DONE:
  - Pump and valve are off.
  - The block waits `DONE_TICKS` cycles, then returns to ORDER with `size`=1 and `drink` kept.
  - confirm or cancel returns to ORDER early.
- Priority within one cycle: cancel > confirm > up/down.
  - up and down together produce no change.
  - A confirm accompanied by up or down advances the state without editing the field.
- The pour product is computed at full width: 4 bits × `$clog2(TICKS_PER_UNIT)`, sized for `9*TICKS_PER_UNIT`. It never truncates.
- `drink` and `size` cannot change during START or DONE.

## Timing
- All outputs are registered.
- A button pulse at edge N appears on the outputs after edge N+1 (one cycle of latency).
- `pump_on` is high for exactly `size*TICKS_PER_UNIT` cycles, with no early or late cycle.
- `state`=DONE on the cycle after the last pump cycle.
- Asserting `rst_n` during START clears `pump_on` and `valve` asynchronously, with no wait for `clk`.
- Release of `rst_n` is synchronised by the top level.

## Configuration
- `ORDER_CTRL_TIMEOUT_EN` defined:
  - An idle counter runs in CUSTOMIZE. Any button pulse clears it.
  - After `IDLE_TICKS` cycles with no press, the state returns to ORDER as if cancel were pressed.
- Undefined: the idle counter is not built and CUSTOMIZE waits indefinitely.

## Structure
- Shared package `cocktail_pkg`:
  - state encodings `ST_ORDER`, `ST_CUSTOMIZE`, `ST_START`, `ST_DONE` in a 2-bit enum typedef;
  - `DRINK_COUNT`=7, `SIZE_MIN`=1, `SIZE_MAX`=9.
  - The display stage imports the same encodings.
- Sub-module `pour_timer`:
  - inputs: load, load value, abort;
  - outputs: `running` and a one-cycle `expired`;
  - it also serves the DONE hold count.

## Test plan
- Release reset, then pulse up ×8 in ORDER → `drink` steps 1..6, 0, 1 and ends at 1; `state`=00.
- confirm, up ×10, down ×1 → `state`=01, `size` saturates at 9 and then reads 8.
- With `TICKS_PER_UNIT`=4, `size`=3: confirm → `pump_on` high exactly 12 cycles, `valve`=0000010 for `drink`=1, then `state`=11, then ORDER after `DONE_TICKS`.
- cancel on the 5th pour cycle → next edge `pump_on`=0, `valve`=0, `state`=00, `size`=1, `drink` kept.
- confirm and cancel in the same cycle in CUSTOMIZE → ORDER. up and down together → no change.
- `rst_n` low mid-pour → `pump_on` falls before the next `clk` edge; all outputs read their reset values. With `ORDER_CTRL_TIMEOUT_EN` and `IDLE_TICKS`=20: idle in CUSTOMIZE → ORDER at cycle 20.

Source files
------------

// File: rtl/cocktail_pkg.sv
// Shared definitions for the cocktail machine order path: state encodings,
// drink/size limits and small field-stepping helpers. The display stage
// imports the same encodings.
package cocktail_pkg;

    typedef enum logic [1:0] {
        ST_ORDER     = 2'b00,
        ST_CUSTOMIZE = 2'b01,
        ST_START     = 2'b10,
        ST_DONE      = 2'b11
    } order_state_e;

    localparam int          DRINK_COUNT = 7;
    localparam logic [2:0]  DRINK_LAST  = 3'(DRINK_COUNT - 1);
    localparam logic [3:0]  SIZE_MIN    = 4'd1;
    localparam logic [3:0]  SIZE_MAX    = 4'd9;

    // Step the drink index one place, wrapping around the menu in both directions.
    function automatic logic [2:0] drink_step(input logic [2:0] d, input logic up);
        if (up) begin
            return (d >= DRINK_LAST) ? 3'd0 : d + 3'd1;
        end
        return (d == 3'd0) ? DRINK_LAST : d - 3'd1;
    endfunction

    // Step the size one unit, pinned at both ends of the range.
    function automatic logic [3:0] size_step(input logic [3:0] s, input logic up);
        if (up) begin
            return (s >= SIZE_MAX) ? SIZE_MAX : s + 4'd1;
        end
        return (s <= SIZE_MIN) ? SIZE_MIN : s - 4'd1;
    endfunction

    // One-hot valve pattern for a drink index.
    function automatic logic [6:0] drink_valve(input logic [2:0] d);
        return 7'd1 << d;
    endfunction

endpackage

// File: rtl/cocktail_order_ctrl_pour_timer.sv
// Down-counter shared by the pour phase and the DONE hold. A load starts a
// run of exactly load_val_i cycles; 'expired' marks the final cycle of the run
// so the owner can change state on the same edge the count reaches zero.
module pour_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             abort_i,
    output logic             running_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Abort wins over load; load wins over counting down.
    always_comb begin
        count_d = count_q;
        if (abort_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign running_o = (count_q != '0);
    assign expired_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/cocktail_order_ctrl.sv
// Order controller: turns debounced button pulses into state/drink/size for
// the display and runs the timed pour (pump + one-hot valve).
// Optional build macro ORDER_CTRL_TIMEOUT_EN adds a CUSTOMIZE inactivity
// timeout of IDLE_TICKS cycles that behaves like a cancel.
module cocktail_order_ctrl
    import cocktail_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 50_000_000,
    parameter int DONE_TICKS     = 100_000_000,
    parameter int IDLE_TICKS     = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_confirm,
    input  logic       btn_cancel,
    output logic [1:0] state,
    output logic [2:0] drink,
    output logic [3:0] size,
    output logic       pump_on,
    output logic [6:0] valve
);

    // 4-bit size times the per-unit tick count, sized so 9*TICKS_PER_UNIT fits.
    localparam int PROD_W = 4 + $clog2(TICKS_PER_UNIT);
    localparam int DONE_W = $clog2(DONE_TICKS + 1);
    localparam int CNT_W  = (PROD_W > DONE_W) ? PROD_W : DONE_W;

    logic [1:0]       rst_sync_q;
    logic             rst_n_sync;

    order_state_e     state_q, state_d;
    logic [2:0]       drink_q, drink_d;
    logic [3:0]       size_q, size_d;
    logic             pump_q;
    logic [6:0]       valve_q;

    logic             tmr_load, tmr_abort, tmr_running, tmr_expired;
    logic [CNT_W-1:0] tmr_val, pour_ticks;
    logic             edit_up, edit_dn, idle_timeout;

    // Reset asserts asynchronously and releases after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_sync = rst_sync_q[1];

    // up and down together cancel each other out.
    assign edit_up    = btn_up & ~btn_down;
    assign edit_dn    = btn_down & ~btn_up;
    assign pour_ticks = CNT_W'(size_q) * CNT_W'(TICKS_PER_UNIT);

`ifdef ORDER_CTRL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              any_btn;

    assign any_btn      = btn_up | btn_down | btn_confirm | btn_cancel;
    assign idle_timeout = (state_q == ST_CUSTOMIZE) && !any_btn &&
                          (idle_q == IDLE_W'(IDLE_TICKS - 1));

    // Idle count runs only while customizing; any press restarts it.
    always_comb begin
        idle_d = idle_q + IDLE_W'(1);
        if (state_q != ST_CUSTOMIZE || any_btn || idle_timeout) begin
            idle_d = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // No timeout in this build; IDLE_TICKS is referenced only to keep it live.
    assign idle_timeout = 1'b0 & (IDLE_TICKS < 0);
`endif

    // Next-state logic; priority is cancel, then confirm, then up/down.
    always_comb begin
        state_d   = state_q;
        drink_d   = drink_q;
        size_d    = size_q;
        tmr_load  = 1'b0;
        tmr_abort = 1'b0;
        tmr_val   = '0;
        case (state_q)
            ST_ORDER: begin
                if (!btn_cancel) begin
                    if (btn_confirm) begin
                        state_d = ST_CUSTOMIZE;
                    end else if (edit_up) begin
                        drink_d = drink_step(drink_q, 1'b1);
                    end else if (edit_dn) begin
                        drink_d = drink_step(drink_q, 1'b0);
                    end
                end
            end
            ST_CUSTOMIZE: begin
                if (btn_cancel || idle_timeout) begin
                    state_d = ST_ORDER;
                    size_d  = SIZE_MIN;
                end else if (btn_confirm) begin
                    state_d  = ST_START;
                    tmr_load = 1'b1;
                    tmr_val  = pour_ticks;
                end else if (edit_up) begin
                    size_d = size_step(size_q, 1'b1);
                end else if (edit_dn) begin
                    size_d = size_step(size_q, 1'b0);
                end
            end
            ST_START: begin
                if (btn_cancel) begin
                    state_d   = ST_ORDER;
                    size_d    = SIZE_MIN;
                    tmr_abort = 1'b1;
                end else if (tmr_expired || !tmr_running) begin
                    // Last pump cycle: reuse the timer for the DONE hold.
                    state_d  = ST_DONE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(DONE_TICKS);
                end
            end
            ST_DONE: begin
                if (btn_cancel || btn_confirm || tmr_expired || !tmr_running) begin
                    state_d   = ST_ORDER;
                    size_d    = SIZE_MIN;
                    tmr_abort = 1'b1;
                end
            end
            default: state_d = ST_ORDER;
        endcase
    end

    // Output registers; pump and valve follow the next state so they move on the same edge.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= ST_ORDER;
            drink_q <= 3'd0;
            size_q  <= SIZE_MIN;
            pump_q  <= 1'b0;
            valve_q <= 7'd0;
        end else begin
            state_q <= state_d;
            drink_q <= drink_d;
            size_q  <= size_d;
            pump_q  <= (state_d == ST_START);
            valve_q <= (state_d == ST_START) ? drink_valve(drink_d) : 7'd0;
        end
    end

    pour_timer #(
        .CNT_W (CNT_W)
    ) u_pour_timer (
        .clk        (clk),
        .rst_n      (rst_n_sync),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .abort_i    (tmr_abort),
        .running_o  (tmr_running),
        .expired_o  (tmr_expired)
    );

    assign state   = state_q;
    assign drink   = drink_q;
    assign size    = size_q;
    assign pump_on = pump_q;
    assign valve   = valve_q;

endmodule
